// File: rtl/tl_error_buffer_if.sv
// Channel bundle for the error-device buffer: upstream A/D on the "in" side,
// downstream A/D toward the error device on the "out" side.
interface tl_error_buffer_if;
   logic         auto_in_a_valid;
   logic [2:0]   auto_in_a_bits_opcode;
   logic [127:0] auto_in_a_bits_address;
   logic         auto_in_a_ready;

   logic         auto_in_d_ready;
   logic         auto_in_d_valid;
   logic [2:0]   auto_in_d_bits_opcode;
   logic [1:0]   auto_in_d_bits_param;
   logic [1:0]   auto_in_d_bits_size;
   logic         auto_in_d_bits_denied;
   logic         auto_in_d_bits_corrupt;

   logic         auto_out_a_valid;
   logic [2:0]   auto_out_a_bits_opcode;
   logic [127:0] auto_out_a_bits_address;
   logic         auto_out_a_ready;

   logic         auto_out_d_valid;
   logic [2:0]   auto_out_d_bits_opcode;
   logic [1:0]   auto_out_d_bits_param;
   logic [1:0]   auto_out_d_bits_size;
   logic         auto_out_d_bits_denied;
   logic         auto_out_d_bits_corrupt;
   logic         auto_out_d_ready;

   // buffer side
   modport slave (
      input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_address,
      output auto_in_a_ready,
      input  auto_in_d_ready,
      output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
             auto_in_d_bits_size, auto_in_d_bits_denied, auto_in_d_bits_corrupt,
      output auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_address,
      input  auto_out_a_ready,
      input  auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param,
             auto_out_d_bits_size, auto_out_d_bits_denied, auto_out_d_bits_corrupt,
      output auto_out_d_ready
   );

   // environment side (upstream client plus downstream error device)
   modport master (
      output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_address,
      input  auto_in_a_ready,
      output auto_in_d_ready,
      input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param,
             auto_in_d_bits_size, auto_in_d_bits_denied, auto_in_d_bits_corrupt,
      input  auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_address,
      output auto_out_a_ready,
      output auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param,
             auto_out_d_bits_size, auto_out_d_bits_denied, auto_out_d_bits_corrupt,
      input  auto_out_d_ready
   );
endinterface

// File: rtl/tl_error_buffer.sv
// Two-entry A and D buffers in front of the error device, with an in-flight
// limiter that stops forwarding A requests once MAX_INFLIGHT are unanswered.
// Payloads pass through untouched; readies come from registered counts only.
module tl_error_buffer #(
   parameter int MAX_INFLIGHT = 2
) (
   input  logic            clock,
   input  logic            reset,
   tl_error_buffer_if.slave bus
);

   localparam logic [1:0] MAX_INF = 2'(MAX_INFLIGHT);

   // D entry layout: {opcode[2:0], param[1:0], size[1:0], denied, corrupt}
   logic [2:0]   a_opcode_mem  [2];
   logic [127:0] a_address_mem [2];
   logic [8:0]   d_mem         [2];

   logic       a_wr_ptr, a_rd_ptr;
   logic [1:0] a_count;
   logic       d_wr_ptr, d_rd_ptr;
   logic [1:0] d_count;
   logic [1:0] inflight;

   logic a_ready, a_out_valid, a_enq, a_deq;
   logic d_ready, d_in_valid, d_enq, d_deq;

   assign a_ready     = (a_count < 2'd2);
   assign a_out_valid = (a_count != 2'd0) && (inflight < MAX_INF);
   assign a_enq       = bus.auto_in_a_valid && a_ready;
   assign a_deq       = a_out_valid && bus.auto_out_a_ready;

   assign d_ready    = (d_count < 2'd2);
   assign d_in_valid = (d_count != 2'd0);
   assign d_enq      = bus.auto_out_d_valid && d_ready;
   assign d_deq      = d_in_valid && bus.auto_in_d_ready;

   assign bus.auto_in_a_ready         = a_ready;
   assign bus.auto_out_a_valid        = a_out_valid;
   assign bus.auto_out_a_bits_opcode  = a_opcode_mem[a_rd_ptr];
   assign bus.auto_out_a_bits_address = a_address_mem[a_rd_ptr];

   assign bus.auto_out_d_ready       = d_ready;
   assign bus.auto_in_d_valid        = d_in_valid;
   assign bus.auto_in_d_bits_opcode  = d_mem[d_rd_ptr][8:6];
   assign bus.auto_in_d_bits_param   = d_mem[d_rd_ptr][5:4];
   assign bus.auto_in_d_bits_size    = d_mem[d_rd_ptr][3:2];
   assign bus.auto_in_d_bits_denied  = d_mem[d_rd_ptr][1];
   assign bus.auto_in_d_bits_corrupt = d_mem[d_rd_ptr][0];

   // Queue pointers/counts and in-flight accounting; reset drops everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         a_wr_ptr <= 1'b0;
         a_rd_ptr <= 1'b0;
         a_count  <= 2'd0;
         d_wr_ptr <= 1'b0;
         d_rd_ptr <= 1'b0;
         d_count  <= 2'd0;
         inflight <= 2'd0;
      end else begin
         if (a_enq) a_wr_ptr <= ~a_wr_ptr;
         if (a_deq) a_rd_ptr <= ~a_rd_ptr;
         case ({a_enq, a_deq})
            2'b10:   a_count <= a_count + 2'd1;
            2'b01:   a_count <= a_count - 2'd1;
            default: a_count <= a_count;
         endcase

         if (d_enq) d_wr_ptr <= ~d_wr_ptr;
         if (d_deq) d_rd_ptr <= ~d_rd_ptr;
         case ({d_enq, d_deq})
            2'b10:   d_count <= d_count + 2'd1;
            2'b01:   d_count <= d_count - 2'd1;
            default: d_count <= d_count;
         endcase

         // a request counts as answered only once its D beat leaves upstream
         case ({a_deq, d_deq})
            2'b10:   inflight <= inflight + 2'd1;
            2'b01:   inflight <= inflight - 2'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   // Payload storage; written only on enqueue, never reset.
   always_ff @(posedge clock) begin
      if (a_enq) begin
         a_opcode_mem[a_wr_ptr]  <= bus.auto_in_a_bits_opcode;
         a_address_mem[a_wr_ptr] <= bus.auto_in_a_bits_address;
      end
      if (d_enq) begin
         d_mem[d_wr_ptr] <= {bus.auto_out_d_bits_opcode, bus.auto_out_d_bits_param,
                             bus.auto_out_d_bits_size, bus.auto_out_d_bits_denied,
                             bus.auto_out_d_bits_corrupt};
      end
   end

   // A D beat returned upstream with nothing outstanding is a broken downstream device.
   d_without_request: assert property (@(posedge clock) disable iff (reset)
      !(d_deq && (inflight == 2'd0)));

   inflight_bounded: assert property (@(posedge clock) disable iff (reset)
      (inflight <= MAX_INF));

endmodule

// File: doc/tl_error_buffer.md
TL_ERROR_BUFFER -- requirements
Module: tl_error_buffer

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 2, meaning the maximum number of A requests forwarded downstream and not yet answered on in-side D (legal range 1..3).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port auto_in_a_valid, input, 1, upstream A request valid.
REQ-005 SHALL have port auto_in_a_bits_opcode, input, 3, upstream A opcode.
REQ-006 SHALL have port auto_in_a_bits_address, input, 128, upstream A address.
REQ-007 SHALL have port auto_in_a_ready, output, 1, A queue can accept.
REQ-008 SHALL have port auto_in_d_ready, input, 1, upstream accepts D.
REQ-009 SHALL have ports auto_in_d_valid (1), auto_in_d_bits_opcode (3), auto_in_d_bits_param (2), auto_in_d_bits_size (2), auto_in_d_bits_denied (1) and auto_in_d_bits_corrupt (1), all outputs, carrying the buffered D beat upstream.
REQ-010 SHALL have ports auto_out_a_valid (1), auto_out_a_bits_opcode (3) and auto_out_a_bits_address (128), all outputs, plus auto_out_a_ready, input, 1, forming the A channel to the downstream error device.
REQ-011 SHALL have ports auto_out_d_valid (1), auto_out_d_bits_opcode (3), auto_out_d_bits_param (2), auto_out_d_bits_size (2), auto_out_d_bits_denied (1) and auto_out_d_bits_corrupt (1), all inputs, plus auto_out_d_ready, output, 1, forming the D channel from the downstream error device.

Function
REQ-012 SHALL contain a 2-entry FIFO A queue holding {opcode, address} and a 2-entry FIFO D queue holding {opcode, param, size, denied, corrupt}, each with a 2-bit occupancy count (0..2).
REQ-013 SHALL drive auto_in_a_ready = (A count < 2) and auto_out_d_ready = (D count < 2), both from registered state only.
REQ-014 SHALL enqueue A on auto_in_a_valid & auto_in_a_ready and D on auto_out_d_valid & auto_out_d_ready, with no bypass: an entry is visible at the queue head no earlier than the cycle after enqueue (1-cycle minimum latency per queue).
REQ-015 SHALL drive auto_out_a_valid = (A count != 0) & (inflight < MAX_INFLIGHT), with bits taken from the A queue head; dequeue on auto_out_a_valid & auto_out_a_ready.
REQ-016 SHALL drive auto_in_d_valid = (D count != 0), with all D bits taken from the D queue head; dequeue on auto_in_d_valid & auto_in_d_ready.
REQ-017 SHALL hold head payload stable while valid is high and not accepted, on both output channels.
REQ-018 SHALL keep a 2-bit inflight counter: +1 on out-A fire, -1 on in-D fire, unchanged when both fire in the same cycle; every request yields exactly one D beat.
REQ-019 SHALL, when a queue is full, deassert its ready even if a dequeue occurs in the same cycle; simultaneous enqueue and dequeue at count 1 SHALL leave count at 1 and preserve FIFO order.
REQ-020 SHALL implement each queue with 1-bit read/write pointers that wrap 1->0.
REQ-021 SHALL never let inflight exceed MAX_INFLIGHT or underflow below 0; an in-D fire with inflight 0 is illegal stimulus and SHALL be flagged by an assertion, not handled.
REQ-022 SHALL not inspect or modify any payload field; opcode, param, size, denied and corrupt pass through unchanged.

Reset
REQ-023 SHALL, on any cycle with reset high, clear both queue counts and pointers and the inflight count, effective at that clock edge.
REQ-024 SHALL present after reset: auto_in_a_ready=1, auto_out_d_ready=1, auto_out_a_valid=0, auto_in_d_valid=0.
REQ-025 SHALL discard queued entries and in-flight accounting on reset asserted mid-operation; payload registers need not be reset.

Verification
REQ-026 Single request: opcode 3'h4, address 0x1000 at cycle 0 with out ready=1 -> auto_out_a_valid=1 at cycle 1; D beat {opcode 4, denied 1} at cycle 3 -> auto_in_d_valid=1 at cycle 4; inflight returns to 0.
REQ-027 Backpressure: auto_out_a_ready=0 with 3 requests offered -> 2 accepted, auto_in_a_ready=0 from cycle 2; third accepted one cycle after the first out-A fire.
REQ-028 Inflight limit: MAX_INFLIGHT=2, out ready=1, no D returned -> exactly 2 out-A fires, then auto_out_a_valid=0 with A count 1; first in-D fire reopens A one cycle later.
REQ-029 Simultaneous out-A fire and in-D fire at inflight 1 -> inflight stays 1; order of D beats (opcodes 2 then 4) preserved upstream.
REQ-030 D full: auto_in_d_ready=0, 3 D beats offered -> auto_out_d_ready=0 after 2; payloads held stable.
REQ-031 Reset mid-operation: both queues full, inflight 2, reset pulsed one cycle -> next cycle all valids 0, both readies 1, inflight 0.
